multiplexed_ssd_driver: RTL

MULTIPLEXED_SSD_DRIVER -- requirements
Module: multiplexed_ssd_driver

---
 rtl/multiplexed_ssd_driver.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multiplexed_ssd_driver.sv
// Multiplexed seven-segment display driver.
// Scans NUM_DIGITS digits, dwelling SCAN_DIV clocks on each. New content is
// loaded into a pending register and only reaches the display at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   Clock        : single clock, all state on rising edge
//   Resetn       : asynchronous active-low reset
//   Enable       : 0 blanks all outputs; scanning and loads keep running
//   Load         : one-cycle strobe capturing Data/DP into the pending register
//   Data         : hex nibbles, nibble i drives digit i (digit 0 = LS digit)
//   DP           : decimal-point request per digit
//   Segments     : registered segment drive, bit0 = a ... bit6 = g
//   DecimalPoint : registered decimal-point drive, same polarity as Segments
//   DigitSelect  : registered one-hot / one-cold digit enable
//   FrameTick    : one-cycle pulse with the first output cycle of each frame
module multiplexed_ssd_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Enable,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Data,
  input  logic [NUM_DIGITS-1:0]   DP,
  output logic [6:0]              Segments,
  output logic                    DecimalPoint,
  output logic [NUM_DIGITS-1:0]   DigitSelect,
  output logic                    FrameTick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    tick_q, tick_d;

  logic                    dwell_end, frame_end;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [6:0]              seg_on;
  logic [NUM_DIGITS-1:0]   dig_onehot;

  // Active-high gfedcba patterns.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    dwell_end = (presc_q == PRESC_LAST);
    frame_end = dwell_end && (idx_q == IDX_LAST);

    presc_d = dwell_end ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (dwell_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    wrap_d  = frame_end;

    // Boundary transfer is evaluated before the load so a Load landing on
    // the boundary moves the older pending content and becomes the new one.
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (frame_end && pend_flag_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (Load) begin
      pend_data_d = Data;
      pend_dp_d   = DP;
      pend_flag_d = 1'b1;
    end

    // Digit i (i>0) is blank when it and every higher digit are zero.
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (disp_data_q[i*4 +: 4] == 4'h0);
      blank_mask[i] = (LZ_BLANK != 0) && zero_above;
    end

    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    dig_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_onehot[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_data_q[i*4 +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blank_mask[i];
      end
    end
    seg_on = cur_blank ? 7'h00 : seg_decode(cur_nib);

    seg_d    = SEG_OFF;
    dp_out_d = DP_OFF;
    dig_d    = DIG_OFF;
    if (Enable) begin
      seg_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
      dp_out_d = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
      dig_d    = (DIG_ACTIVE_LOW != 0) ? ~dig_onehot : dig_onehot;
    end

    // wrap_q is high for the cycle in which index 0 of the new frame is
    // being registered, so the tick lines up with digit 0 on the outputs.
    tick_d = wrap_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      wrap_q      <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_out_q    <= DP_OFF;
      dig_q       <= DIG_OFF;
      tick_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      wrap_q      <= wrap_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      dig_q       <= dig_d;
      tick_q      <= tick_d;
    end
  end

  assign Segments     = seg_q;
  assign DecimalPoint = dp_out_q;
  assign DigitSelect  = dig_q;
  assign FrameTick    = tick_q;

endmodule
